prog_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the pipeline fetches from. It accepts a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words. Each word is written to consecutive instruction-memory addresses. After the trailing checksum is verified, it releases the core from hold. It sits between the host/debug link and the instruction-memory write port, and drives the pipeline's hold input.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_word_assembler.sv | 40 ++++
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } ldr_state_t;

  localparam int          HDR_BYTES      = 2;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

  // Word-count register width follows the header length.
  localparam int          CNT_W          = 8 * HDR_BYTES;
  localparam int          IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word shifter with running XOR checksum.
import prog_loader_pkg::*;

module word_assembler #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        csum,
  output logic              last
);

  logic [IDX_W-1:0] idx;

  // Shift bytes in MSB-first; clr restarts the byte index and checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
      csum <= CSUM_INIT;
    end else if (clr) begin
      idx  <= '0;
      csum <= CSUM_INIT;
    end else if (shift) begin
      word <= {word[WORD_W-9:0], data};
      csum <= csum ^ data;
      idx  <= idx + 1'b1;
    end
  end

  // The byte currently being shifted completes the word.
  always_comb begin
    last = (idx == IDX_W'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes instruction memory, then releases the core.
import prog_loader_pkg::*;

module prog_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                WORD_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  ldr_state_t        state, state_nxt;
  logic [CNT_W-1:0]  remain;
  logic [ADDR_W-1:0] addr;
  logic              ld_hi, ld_lo, clr, shift, wr;
  logic [WORD_W-1:0] word;
  logic [7:0]        csum;
  logic              last;

  word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift (shift),
    .data  (in_data),
    .word  (word),
    .csum  (csum),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and control decode; in_ready depends on state only, and
  // in_valid is consulted only in states where in_ready is already high.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    clr       = 1'b0;
    shift     = 1'b0;
    wr        = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_HDR_HI;
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_hi     = 1'b1;
          state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_lo     = 1'b1;
          clr       = 1'b1;
          state_nxt = ({remain[CNT_W-1:8], in_data} == '0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift = 1'b1;
          if (last) state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        wr        = 1'b1;
        state_nxt = (remain == CNT_W'(1)) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: if (start) state_nxt = S_HDR_HI;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Remaining-word counter and write address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remain <= '0;
      addr   <= BASE_ADDR;
    end else begin
      if (ld_hi) remain[CNT_W-1:8] <= in_data;
      if (ld_lo) begin
        remain[7:0] <= in_data;
        addr        <= BASE_ADDR;
      end
      if (wr) begin
        remain <= remain - 1'b1;
        addr   <= addr + 1'b1;
      end
    end
  end

  // Outputs are pure decodes of registered state and datapath.
  always_comb begin
    mem_we    = wr;
    mem_addr  = addr;
    mem_wdata = word;
    done      = (state == S_DONE);
    err       = (state == S_ERR);
    core_hold = (state != S_DONE);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (BASE_ADDR 0 and 0xFFFF instances).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready0, mem_we0, core_hold0, done0, err0;
  logic [15:0] mem_addr0;
  logic [31:0] mem_wdata0;
  logic        in_ready1, mem_we1, core_hold1, done1, err1;
  logic [15:0] mem_addr1;
  logic [31:0] mem_wdata1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int xfer_cyc, t_first, t_last;
  logic [47:0] wq0[$];
  logic [47:0] wq1[$];
  logic [7:0]  fb[$];

  prog_loader #(.ADDR_W(16), .WORD_W(32), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .core_hold(core_hold0), .done(done0), .err(err0)
  );

  prog_loader #(.ADDR_W(16), .WORD_W(32), .BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .core_hold(core_hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we0) wq0.push_back({mem_addr0, mem_wdata0});
    if (mem_we1) wq1.push_back({mem_addr1, mem_wdata1});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready0;
      if (ok) xfer_cyc = cyc;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit gappy, input bit poke);
    foreach (fb[i]) begin
      int g;
      g = gappy ? int'($urandom_range(0, 2)) : 0;
      if (poke && i > 0 && (i % 4) == 2) pulse_start();
      send_byte(fb[i], g);
      if (i == 0) t_first = xfer_cyc;
      t_last = xfer_cyc;
    end
  endtask

  task automatic chk_resetvals(input string tag);
    chk({tag, "_ready"}, in_ready0, 0);
    chk({tag, "_we"},    mem_we0, 0);
    chk({tag, "_addr"},  mem_addr0, 16'h0000);
    chk({tag, "_wdata"}, mem_wdata0, 0);
    chk({tag, "_hold"},  core_hold0, 1);
    chk({tag, "_done"},  done0, 0);
    chk({tag, "_err"},   err0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk_resetvals("rst");
    chk("rst_addr1", mem_addr1, 16'hFFFF);
    tick();
    rst = 1'b1;
    tick();

    // N=2 good checksum; also exercises address wrap on dut1
    wq0.delete(); wq1.delete();
    pulse_start();
    fb = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    send_frame(0, 0);
    chk("n2_hold_pre_csum", core_hold0, 1);
    fb = '{8'h04};
    send_byte(8'h04, 0);
    t_last = xfer_cyc;
    chk("n2_hold_fall", core_hold0, 0);
    chk("n2_done", done0, 1);
    chk("n2_err", err0, 0);
    chk("n2_frame_cycles", t_last - t_first, 12);
    chk("n2_nwr", wq0.size(), 2);
    if (wq0.size() == 2) begin
      chk("n2_wr0", wq0[0], {16'h0000, 32'h01020304});
      chk("n2_wr1", wq0[1], {16'h0001, 32'hA0B0C0D0});
    end
    chk("wrap_nwr", wq1.size(), 2);
    if (wq1.size() == 2) begin
      chk("wrap_wr0", wq1[0], {16'hFFFF, 32'h01020304});
      chk("wrap_wr1", wq1[1], {16'h0000, 32'hA0B0C0D0});
    end
    chk("wrap_done", done1, 1);

    // in_valid in DONE is not accepted
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    chk("done_noready", in_ready0, 0);
    tick();
    in_valid = 1'b0;
    chk("done_stays", done0, 1);

    // Same frame with bad checksum
    wq0.delete(); wq1.delete();
    pulse_start();
    chk("restart_done_clr", done0, 0);
    chk("restart_hold", core_hold0, 1);
    fb = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h05};
    send_frame(0, 0);
    chk("bad_err", err0, 1);
    chk("bad_done", done0, 0);
    chk("bad_hold", core_hold0, 1);
    chk("bad_nwr", wq0.size(), 2);
    if (wq0.size() == 2) chk("bad_wr1", wq0[1], {16'h0001, 32'hA0B0C0D0});

    // Start after error, then an N=0 good frame
    wq0.delete(); wq1.delete();
    pulse_start();
    chk("err_clr", err0, 0);
    chk("err_clr_hold", core_hold0, 1);
    fb = '{8'h00, 8'h00, 8'h00};
    send_frame(0, 0);
    chk("n0_done", done0, 1);
    chk("n0_err", err0, 0);
    chk("n0_nwr", wq0.size(), 0);
    chk("n0_frame_cycles", t_last - t_first, 2);

    // N=0 with bad checksum
    pulse_start();
    fb = '{8'h00, 8'h00, 8'h01};
    send_frame(0, 0);
    chk("n0bad_err", err0, 1);
    chk("n0bad_done", done0, 0);
    chk("n0bad_nwr", wq0.size(), 0);

    // N=3 with in_valid gaps and ignored start pulses mid-load
    wq0.delete(); wq1.delete();
    pulse_start();
    fb = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
    send_frame(1, 1);
    chk("gap_done", done0, 1);
    chk("gap_hold", core_hold0, 0);
    chk("gap_nwr", wq0.size(), 3);
    if (wq0.size() == 3) begin
      chk("gap_wr0", wq0[0], {16'h0000, 32'h11223344});
      chk("gap_wr1", wq0[1], {16'h0001, 32'h55667788});
      chk("gap_wr2", wq0[2], {16'h0002, 32'h99AABBCC});
    end
    chk("gap_nwr1", wq1.size(), 3);
    if (wq1.size() == 3) chk("gap_wr1_2", wq1[2], {16'h0001, 32'h99AABBCC});

    // Reset after 2 bytes of word 1
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b0;
    #1;
    chk_resetvals("midrst");
    tick();
    rst = 1'b1;
    tick();
    wq0.delete(); wq1.delete();
    pulse_start();
    fb = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame(0, 0);
    chk("post_rst_done", done0, 1);
    chk("post_rst_nwr", wq0.size(), 1);
    if (wq0.size() == 1) chk("post_rst_wr0", wq0[0], {16'h0000, 32'hDEADBEEF});

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
